// File: rtl/lane_demand_pkg.sv
// Shared definitions for the lane demand detector: lane count, parameter
// defaults and the per-lane state encoding.
package lane_demand_pkg;

  localparam int unsigned NUM_LANES           = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_MAX_WAIT        = 255;
  localparam int unsigned DEF_WAIT_W          = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVING  = 2'd2,
    RELEASED = 2'd3
  } lane_state_e;

endpackage

// File: rtl/lane_demand_fsm.sv
// One lane: sensor synchroniser, debounce, demand latch FSM and starvation
// wait counter. Outputs depend on registered state only.
module lane_demand_fsm
  import lane_demand_pkg::*;
#(
  parameter int unsigned LANE_ID         = 0,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_WAIT        = DEF_MAX_WAIT,
  parameter int unsigned WAIT_W          = DEF_WAIT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_i,
  input  logic match_i,
  output logic t_o,
  output logic starve_o
);

  localparam int unsigned       DEB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  if (LANE_ID >= NUM_LANES) begin : g_bad_lane_id
    $error("lane_demand_fsm: LANE_ID out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || MAX_WAIT < 1) begin : g_bad_counts
    $error("lane_demand_fsm: DEBOUNCE_CYCLES and MAX_WAIT must be >= 1");
  end
  if ((64'(MAX_WAIT) >> WAIT_W) != 64'd0) begin : g_bad_wait_w
    $error("lane_demand_fsm: WAIT_W too narrow for MAX_WAIT");
  end

  lane_state_e       state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        sync_q;
  logic              s;

  assign s = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      deb_q   <= '0;
      wait_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], sensor_i};
      state_q <= state_d;
      deb_q   <= deb_d;
      wait_q  <= wait_d;
    end
  end

  // Counters default to zero so every state change clears them.
  always_comb begin
    state_d = state_q;
    deb_d   = '0;
    wait_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          if (deb_q == DEB_LAST) state_d = PENDING;
          else                   deb_d   = deb_q + 1'b1;
        end
      end
      PENDING: begin
        if (match_i)               state_d = SERVING;
        else if (wait_q == WAIT_MAX) wait_d = wait_q;
        else                       wait_d  = wait_q + 1'b1;
      end
      SERVING: begin
        // Losing green takes priority over finishing the release count.
        if (!match_i) begin
          state_d = s ? PENDING : IDLE;
        end else if (!s) begin
          if (deb_q == DEB_LAST) state_d = RELEASED;
          else                   deb_d   = deb_q + 1'b1;
        end
      end
      RELEASED: begin
        if (!match_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    t_o      = (state_q == PENDING) || (state_q == SERVING);
    starve_o = (state_q == PENDING) && (wait_q == WAIT_MAX);
  end

endmodule

// File: rtl/lane_demand_detector.sv
// Conditions four raw loop sensors into per-lane demand (t) and starvation
// flags for the 4-way traffic controller.
module lane_demand_detector
  import lane_demand_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MAX_WAIT        = DEF_MAX_WAIT,
  parameter int unsigned WAIT_W          = DEF_WAIT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] sensor,
  input  logic [1:0]           side,
  input  logic                 g,
  output logic [NUM_LANES-1:0] t,
  output logic [NUM_LANES-1:0] starve
);

  logic [NUM_LANES-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      match[i] = g && (side == 2'(i));
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_demand_fsm #(
      .LANE_ID         (i),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .MAX_WAIT        (MAX_WAIT),
      .WAIT_W          (WAIT_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .sensor_i (sensor[i]),
      .match_i  (match[i]),
      .t_o      (t[i]),
      .starve_o (starve[i])
    );
  end

endmodule

// File: tb/tb_lane_demand_detector.sv
// Randomised scoreboard bench for lane_demand_detector with a per-lane
// behavioural reference model.
module tb_lane_demand_detector;

  localparam int DC   = 4;
  localparam int MAXW = 10;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor;
  logic [1:0] side;
  logic       g;
  logic [3:0] t;
  logic [3:0] starve;

  lane_demand_detector #(
    .DEBOUNCE_CYCLES (DC),
    .MAX_WAIT        (MAXW),
    .WAIT_W          (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor),
    .side   (side),
    .g      (g),
    .t      (t),
    .starve (starve)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] starve;
  } resp_t;

  resp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    running = 0;

  // Reference model: latched demand, service and release flags plus
  // run lengths of the synchronised sensor and the pending age.
  bit demand[4], served[4], done[4];
  int hi_run[4], lo_run[4], age[4];
  bit hist[4][$];

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      demand[n] = 0; served[n] = 0; done[n] = 0;
      hi_run[n] = 0; lo_run[n] = 0; age[n] = 0;
      hist[n].delete();
    end
  endtask

  task automatic model_edge(output resp_t r);
    bit s, m;
    for (int n = 0; n < 4; n++) begin
      s = (hist[n].size() >= 2) ? hist[n][hist[n].size()-2] : 1'b0;
      hist[n].push_back(sensor[n]);
      if (hist[n].size() > 3) void'(hist[n].pop_front());
      m = g && (int'(side) == n);
      if (done[n]) begin
        if (!m) done[n] = 0;
        hi_run[n] = 0;
      end else if (!demand[n]) begin
        hi_run[n] = s ? hi_run[n] + 1 : 0;
        if (hi_run[n] >= DC) begin demand[n] = 1; hi_run[n] = 0; age[n] = 0; end
      end else if (!served[n]) begin
        if (m) begin served[n] = 1; age[n] = 0; lo_run[n] = 0; end
        else age[n]++;
      end else begin
        if (!m) begin
          served[n] = 0; demand[n] = s; age[n] = 0; lo_run[n] = 0; hi_run[n] = 0;
        end else begin
          lo_run[n] = s ? 0 : lo_run[n] + 1;
          if (lo_run[n] >= DC) begin
            served[n] = 0; demand[n] = 0; done[n] = 1; lo_run[n] = 0;
          end
        end
      end
      r.t[n]      = demand[n];
      r.starve[n] = demand[n] && !served[n] && (age[n] >= MAXW);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (t !== 4'b0000) begin
      errors++;
      $display("FAIL %s.t: got %b, expected 0000", name, t);
    end
    checks++;
    if (starve !== 4'b0000) begin
      errors++;
      $display("FAIL %s.starve: got %b, expected 0000", name, starve);
    end
  endtask

  // Monitor: one registered response per cycle, compared mid-cycle.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (t !== e.t || starve !== e.starve) begin
            errors++;
            $display("FAIL cycle_out @%0t: t=%b starve=%b, expected t=%b starve=%b",
                     $time, t, starve, e.t, e.starve);
          end
        end
      end
    end
  end

  initial begin
    resp_t r;
    reset  = 1'b1;
    sensor = '0;
    side   = '0;
    g      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    #1 running = 1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge(r);
      exp_q.push_back(r);
      #1;
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 7) == 0) sensor[n] = ~sensor[n];
      if ($urandom_range(0, 11) == 0) g = ~g;
      if ($urandom_range(0, 9) == 0) side = 2'($urandom_range(0, 3));
      if (cyc % 900 == 450) begin
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("reset_mid");
        reset = 1'b0;
        model_reset();
      end
    end

    @(negedge clk);
    #1 running = 0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
